// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one OBI-style memory port between the instruction-fetch interface
// and the load/store unit. Data requests win by default. Instruction fetch
// wins once it has lost STARVE_LIMIT consecutive cycles. After a request has
// been offered to the memory it is held stable until it is granted. Granted
// transactions are recorded in an in-order owner FIFO, and each response is
// routed back to the side that issued it.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   instr_*                  fetch side: req/addr in; gnt/rvalid/err/rdata out
//   data_*                   load/store side: req/we/be/addr/wdata in;
//                            gnt/rvalid/err/rdata out
//   mem_*_o                  downstream request: req/we/be/addr/wdata
//   mem_gnt_i, mem_rvalid_i, downstream grant and response (valid, error, data)
//   mem_err_i, mem_rdata_i
//   outstanding_o            registered owner-FIFO occupancy
//   protocol_err_o           pulses when a response arrives with nothing outstanding
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               instr_req_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic                               instr_err_o,
    input  logic [31:0]                        instr_addr_i,
    output logic [31:0]                        instr_rdata_o,
    input  logic                               data_req_i,
    output logic                               data_gnt_o,
    output logic                               data_rvalid_o,
    output logic                               data_err_o,
    input  logic                               data_we_i,
    input  logic [3:0]                         data_be_i,
    input  logic [31:0]                        data_addr_i,
    input  logic [31:0]                        data_wdata_i,
    output logic [31:0]                        data_rdata_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [3:0]                         mem_be_o,
    output logic [31:0]                        mem_addr_o,
    output logic [31:0]                        mem_wdata_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic                               mem_err_i,
    input  logic [31:0]                        mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STV_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_INSTR = 1'b1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    logic             state_q, state_d;
    logic             holdOwner_q, holdOwner_d;
    logic [STV_W-1:0] starveCnt_q, starveCnt_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ownerMem_q [MAX_OUTSTANDING];

    logic fifoFull;
    logic fifoEmpty;
    logic reqRaw;
    logic ownerSel;
    logic pushRaw;
    logic popRaw;
    logic headOwner;
    logic outEn;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifoFull  = (count_q == FULL_CNT);
    assign fifoEmpty = (count_q == '0);
    assign headOwner = ownerMem_q[rdPtr_q];

    // Pick the request offered downstream this cycle. A held request is
    // replayed unchanged. A fresh request is only offered when the FIFO has
    // room, and that check uses the registered count only, so a response
    // popping in the same cycle never feeds combinationally into mem_req_o.
    always_comb begin
        reqRaw   = 1'b0;
        ownerSel = OWN_DATA;
        if (state_q == ST_HOLD) begin
            reqRaw   = 1'b1;
            ownerSel = holdOwner_q;
        end else if (!fifoFull && (instr_req_i || data_req_i)) begin
            reqRaw   = 1'b1;
            ownerSel = (instr_req_i && (!data_req_i || starveCnt_q == STARVE_MAX))
                       ? OWN_INSTR : OWN_DATA;
        end
    end

    assign pushRaw = reqRaw && mem_gnt_i;
    assign popRaw  = mem_rvalid_i && !fifoEmpty;

    // Every output is forced low while reset is asserted. Requesters may keep
    // their req high through reset, and the bus must still look idle.
    assign outEn = !RST;

    assign mem_req_o   = outEn && reqRaw;
    assign mem_we_o    = outEn && reqRaw && (ownerSel == OWN_DATA) && data_we_i;
    assign mem_be_o    = !(outEn && reqRaw)  ? 4'h0  :
                         (ownerSel == OWN_INSTR) ? 4'hF : data_be_i;
    assign mem_addr_o  = !(outEn && reqRaw)  ? 32'h0 :
                         (ownerSel == OWN_INSTR) ? instr_addr_i : data_addr_i;
    assign mem_wdata_o = (outEn && reqRaw && ownerSel == OWN_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = outEn && pushRaw && (ownerSel == OWN_INSTR);
    assign data_gnt_o  = outEn && pushRaw && (ownerSel == OWN_DATA);

    assign instr_rvalid_o = outEn && popRaw && (headOwner == OWN_INSTR);
    assign data_rvalid_o  = outEn && popRaw && (headOwner == OWN_DATA);
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;

    assign protocol_err_o = outEn && mem_rvalid_i && fifoEmpty;
    assign outstanding_o  = count_q;

    // Next-state logic for the ARB/HOLD FSM, the starvation counter and the
    // owner FIFO. HOLD is only entered from ARB when the FIFO has room, so
    // the grant that leaves HOLD always has a free slot to push into.
    always_comb begin
        state_d     = state_q;
        holdOwner_d = holdOwner_q;
        case (state_q)
            ST_ARB: begin
                if (reqRaw && !mem_gnt_i) begin
                    state_d     = ST_HOLD;
                    holdOwner_d = ownerSel;
                end
            end
            default: begin
                if (mem_gnt_i) begin
                    state_d = ST_ARB;
                end
            end
        endcase

        starveCnt_d = '0;
        if (instr_req_i && !(pushRaw && ownerSel == OWN_INSTR)) begin
            starveCnt_d = (starveCnt_q == STARVE_MAX) ? STARVE_MAX : starveCnt_q + 1'b1;
        end

        wrPtr_d = pushRaw ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d = popRaw  ? ptrInc(rdPtr_q) : rdPtr_q;
        case ({pushRaw, popRaw})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers. Reset drops all in-flight tracking, so any response
    // that arrives later is reported as unexpected.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_ARB;
            holdOwner_q <= OWN_DATA;
            starveCnt_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ownerMem_q[i] <= OWN_DATA;
            end
        end else begin
            state_q     <= state_d;
            holdOwner_q <= holdOwner_d;
            starveCnt_q <= starveCnt_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            if (pushRaw) begin
                ownerMem_q[wrPtr_q] <= ownerSel;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. It runs directed scenarios
// (single fetch, starvation, grant stall, FIFO full, unexpected response,
// mid-operation reset) and then randomized traffic. All of it is checked
// against a behavioural model that keeps outstanding owners in a queue.
module tb_mem_port_arbiter;

    localparam int MAX_OUT = 2;
    localparam int LIMIT   = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_err_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        protocol_err_o;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: queue of owners still waiting for a response
    // (1 = instruction, 0 = data), plus the request being held and the count
    // of consecutive instruction losses.
    bit ownerQ[$];
    bit heldValid;
    bit heldOwner;
    int starve;
    bit lastIGnt;
    bit lastDGnt;

    // Compare one observed value against its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Return the model to its post-reset state.
    task automatic modelReset();
        ownerQ.delete();
        heldValid = 1'b0;
        heldOwner = 1'b0;
        starve    = 0;
        lastIGnt  = 1'b0;
        lastDGnt  = 1'b0;
    endtask

    // Drive one cycle of inputs, check every output mid-cycle against the
    // model, advance the model, then return just after the next rising edge.
    task automatic applyStimulus(input bit ir, input logic [31:0] ia,
                                 input bit dr, input bit dwe, input logic [3:0] dbe,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input bit mg, input bit mrv, input bit merr,
                                 input logic [31:0] mrd);
        bit req, own, gnt, pop, head, full;
        instr_req_i  = ir;  instr_addr_i = ia;
        data_req_i   = dr;  data_we_i    = dwe; data_be_i = dbe;
        data_addr_i  = da;  data_wdata_i = dwd;
        mem_gnt_i    = mg;  mem_rvalid_i = mrv; mem_err_i = merr; mem_rdata_i = mrd;
        @(negedge CLK);
        full = (ownerQ.size() >= MAX_OUT);
        req  = 1'b0;
        own  = 1'b0;
        if (heldValid) begin
            req = 1'b1;
            own = heldOwner;
        end else if (!full && (ir || dr)) begin
            req = 1'b1;
            own = ir && (!dr || starve >= LIMIT);
        end
        gnt  = req && mg;
        pop  = mrv && (ownerQ.size() > 0);
        head = pop ? ownerQ[0] : 1'b0;

        checkOutput("outstanding", 32'(outstanding_o), 32'(ownerQ.size()));
        checkOutput("mem_req",     32'(mem_req_o),     32'(req));
        checkOutput("mem_addr",    mem_addr_o,         !req ? 32'h0 : (own ? ia : da));
        checkOutput("mem_we",      32'(mem_we_o),      32'(req && !own && dwe));
        checkOutput("mem_be",      32'(mem_be_o),      !req ? 32'h0 : (own ? 32'hF : 32'(dbe)));
        checkOutput("mem_wdata",   mem_wdata_o,        (req && !own) ? dwd : 32'h0);
        checkOutput("instr_gnt",   32'(instr_gnt_o),   32'(gnt && own));
        checkOutput("data_gnt",    32'(data_gnt_o),    32'(gnt && !own));
        checkOutput("instr_rvalid", 32'(instr_rvalid_o), 32'(pop && head));
        checkOutput("data_rvalid", 32'(data_rvalid_o), 32'(pop && !head));
        checkOutput("instr_err",   32'(instr_err_o),   32'(pop && head && merr));
        checkOutput("data_err",    32'(data_err_o),    32'(pop && !head && merr));
        checkOutput("instr_rdata", instr_rdata_o,      (pop && head) ? mrd : 32'h0);
        checkOutput("data_rdata",  data_rdata_o,       (pop && !head) ? mrd : 32'h0);
        checkOutput("protocol_err", 32'(protocol_err_o), 32'(mrv && ownerQ.size() == 0));

        if (pop) void'(ownerQ.pop_front());
        if (gnt) ownerQ.push_back(own);
        heldValid = req && !gnt;
        heldOwner = own;
        if (ir && !(gnt && own)) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
        else                     starve = 0;
        lastIGnt = gnt && own;
        lastDGnt = gnt && !own;
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycle(input bit mrv, input logic [31:0] mrd);
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, mrv, 0, mrd);
    endtask

    // Resolve any held request and drain every outstanding response.
    task automatic drainAll();
        for (int k = 0; k < 20; k++) begin
            if (!heldValid && ownerQ.size() == 0) break;
            applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, ownerQ.size() > 0, 0, $urandom);
        end
    endtask

    bit          iPend, dPend, dWe;
    logic [31:0] iAddr, dAddr, dWd;
    logic [3:0]  dBe;

    initial begin
        RST = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h44;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
        modelReset();
        #2;
        checkOutput("rst_mem_req",   32'(mem_req_o),      32'h0);
        checkOutput("rst_instr_gnt", 32'(instr_gnt_o),    32'h0);
        checkOutput("rst_outstand",  32'(outstanding_o),  32'h0);
        checkOutput("rst_proto_err", 32'(protocol_err_o), 32'h0);
        checkOutput("rst_rvalids",   32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Single fetch granted immediately, answered two cycles later.
        applyStimulus(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        idleCycle(0, 32'h0);
        idleCycle(1, 32'h13);
        idleCycle(0, 32'h0);

        // Both sides request continuously; fetch must win on the fifth cycle.
        for (int c = 0; c < 8; c++)
            applyStimulus(1, 32'h100, 1, 0, 4'h7, 32'h2000 + 32'(c), 32'h0, 1, 1, 0, 32'(c));
        drainAll();

        // Store stalled by the memory while fetch arrives behind it.
        applyStimulus(0, 32'h0,   1, 1, 4'h3, 32'h1000, 32'hCAFE, 0, 0, 0, 32'h0);
        applyStimulus(1, 32'h200, 1, 1, 4'h3, 32'h1000, 32'hCAFE, 0, 0, 0, 32'h0);
        applyStimulus(1, 32'h200, 1, 1, 4'h3, 32'h1000, 32'hCAFE, 0, 0, 0, 32'h0);
        applyStimulus(1, 32'h200, 1, 1, 4'h3, 32'h1000, 32'hCAFE, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h200, 0, 0, 4'h0, 32'h0,    32'h0,    1, 0, 0, 32'h0);
        drainAll();

        // Fill the FIFO with two data grants, then block a fetch until a pop.
        applyStimulus(0, 32'h0,   1, 0, 4'hF, 32'h3000, 32'h0, 1, 0, 0, 32'h0);
        applyStimulus(0, 32'h0,   1, 0, 4'hF, 32'h3004, 32'h0, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h400, 0, 0, 4'h0, 32'h0,    32'h0, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h400, 0, 0, 4'h0, 32'h0,    32'h0, 1, 1, 1, 32'h55);
        applyStimulus(1, 32'h400, 0, 0, 4'h0, 32'h0,    32'h0, 1, 0, 0, 32'h0);
        drainAll();

        // Unexpected response with nothing outstanding.
        idleCycle(1, 32'hDEAD);
        idleCycle(0, 32'h0);

        // Randomized traffic from two well-behaved OBI requesters.
        iPend = 0; dPend = 0;
        iAddr = 0; dAddr = 0; dWd = 0; dBe = 0; dWe = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!iPend && $urandom_range(0, 99) < 40) begin
                iPend = 1; iAddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dPend && $urandom_range(0, 99) < 70) begin
                dPend = 1; dWe = 1'($urandom_range(0, 1)); dBe = 4'($urandom_range(1, 15));
                dAddr = $urandom; dWd = $urandom;
            end
            applyStimulus(iPend, iAddr, dPend, dWe, dBe, dAddr, dWd,
                          $urandom_range(0, 99) < 65,
                          (ownerQ.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 4),
                          $urandom_range(0, 99) < 20, $urandom);
            if (lastIGnt) iPend = 0;
            if (lastDGnt) dPend = 0;
        end
        drainAll();

        // Reset while a fetch is held with one data transaction outstanding.
        applyStimulus(0, 32'h0,   1, 0, 4'hF, 32'h5000, 32'h0, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h600, 0, 0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0);
        checkOutput("pre_rst_outstand", 32'(outstanding_o), 32'(ownerQ.size()));
        checkOutput("pre_rst_mem_req",  32'(mem_req_o),     32'(heldValid));
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_mem_req",   32'(mem_req_o),     32'h0);
        checkOutput("mid_rst_gnts",      32'({instr_gnt_o, data_gnt_o}), 32'h0);
        checkOutput("mid_rst_outstand",  32'(outstanding_o), 32'h0);
        modelReset();
        #1;
        RST = 1'b0;
        idleCycle(1, 32'hBEEF);
        idleCycle(0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
